// File: rtl/unit_test_result_collector.sv
// Collects per-check pass/fail events, buffers failing IDs in a fall-through FIFO,
// and sequences a test through IDLE/RUN/DRAIN/DONE for the runner.
module unit_test_result_collector #(
  parameter int ID_W  = 8,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             finish,
  input  logic             evt_valid,
  output logic             evt_ready,
  input  logic             evt_pass,
  input  logic [ID_W-1:0]  evt_id,
  output logic             fail_valid,
  input  logic             fail_ready,
  output logic [ID_W-1:0]  fail_id,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             busy,
  output logic             done,
  output logic             test_passed
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nxt;

  logic [ID_W-1:0] mem [DEPTH];
  logic [AW:0]     wptr, rptr, fill;
  logic            empty, full, pop, accept, fail_evt, push, drop, enter_run;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  assign fill     = wptr - rptr;
  assign empty    = (wptr == rptr);
  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop      = !empty && fail_ready;
  assign accept   = evt_valid && evt_ready;
  assign fail_evt = accept && !evt_pass;
  // A pop frees the head slot this edge, so a full FIFO can still take the push.
  assign push     = fail_evt && (!full || pop);
  assign drop     = fail_evt && full && !pop;

  always_comb begin
    state_nxt = state;
    enter_run = 1'b0;
    case (state)
      IDLE:  if (start) begin state_nxt = RUN; enter_run = 1'b1; end
      RUN:   if (finish) state_nxt = DRAIN;
      // Empty now, or the last entry leaves on this edge.
      DRAIN: if (fill == {{AW{1'b0}}, pop}) state_nxt = DONE;
      DONE:  if (start) begin state_nxt = RUN; enter_run = 1'b1; end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || enter_run) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= evt_id;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || enter_run) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
      drop_cnt <= '0;
    end else if (accept) begin
      if (evt_pass) pass_cnt <= sat_inc(pass_cnt);
      else          fail_cnt <= sat_inc(fail_cnt);
      if (drop)     drop_cnt <= sat_inc(drop_cnt);
    end
  end

  assign evt_ready   = (state == RUN);
  assign busy        = (state == RUN) || (state == DRAIN);
  assign done        = (state == DONE);
  assign test_passed = done && (fail_cnt == '0) && (pass_cnt != '0);
  assign fail_valid  = !empty;
  assign fail_id     = empty ? '0 : mem[rptr[AW-1:0]];
endmodule

// File: doc/unit_test_result_collector.md
# unit_test_result_collector

Hardware front end to the unit-test logger and runner. It accepts per-check pass/fail events from a DUT-side checker over a valid/ready port and keeps saturating pass, fail and drop counts. Failing check IDs are buffered in a FIFO that the logger drains, and a test-phase state machine tells the runner when a test has finished and whether it passed.

## Interface
- `ID_W`, default 8: width of the check identifier.
- `DEPTH`, default 8: failure FIFO entries. Must be a power of two, ≥2.
- `CNT_W`, default 16: width of each counter. Counters saturate at 2^CNT_W−1.

- `clk`  in  1  single clock; all logic rising-edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  one-cycle pulse; begins a test.
- `finish`  in  1  one-cycle pulse; ends event collection.
- `evt_valid`  in  1  check event offered.
- `evt_ready`  out  1  collector accepts the event.
- `evt_pass`  in  1  1 = check passed, 0 = failed.
- `evt_id`  in  ID_W  check identifier.
- `fail_valid`  out  1  failure record available.
- `fail_ready`  in  1  logger consumes the record.
- `fail_id`  out  ID_W  ID of the oldest buffered failure.
- `pass_cnt`  out  CNT_W  passes accepted this test.
- `fail_cnt`  out  CNT_W  failures accepted this test (buffered plus dropped).
- `drop_cnt`  out  CNT_W  failures not buffered because the FIFO was full.
- `busy`  out  1  state is RUN or DRAIN.
- `done`  out  1  state is DONE.
- `test_passed`  out  1  valid only while `done`.

## Operation
- States:
  - IDLE: reset state.
  - RUN: collecting events.
  - DRAIN: no new events; waiting for the logger to empty the FIFO.
  - DONE: results held.
- Transitions (evaluated every clock):
  - IDLE→RUN on `start`.
  - RUN→DRAIN on `finish`.
  - DRAIN→DONE when the FIFO is empty. This includes the case where the last pop happens in the same cycle.
  - DONE→RUN on `start`.
  - `start` is ignored in RUN and DRAIN. `finish` is ignored outside RUN.
  - `start` and `finish` in the same cycle while in IDLE or DONE: `start` wins, `finish` is dropped.
- Entering RUN clears all three counters and flushes the FIFO in the same edge. Counters then hold their values through DRAIN and DONE until the next `start`.
- `evt_ready` = 1 only in RUN. It never depends on FIFO fullness, so the checker is never stalled.
- An event is accepted when `evt_valid && evt_ready`:
  - `evt_pass` = 1: `pass_cnt`++.
  - `evt_pass` = 0: `fail_cnt`++. The ID is pushed if the FIFO is not full. If the FIFO is full, `drop_cnt`++, except when a pop occurs that same cycle: then the push succeeds and no drop is counted.
- An event accepted in the same cycle as `finish` is counted; the next state is DRAIN.
- FIFO behaviour:
  - First-word fall-through: `fail_valid` = !empty, and `fail_id` = the head entry.
  - Pop when `fail_valid && fail_ready`.
  - The FIFO can be popped in every state, including IDLE after a flush; in IDLE it is simply empty.
  - Read and write pointers are log2(DEPTH)+1 bits and wrap naturally. Full = MSBs differ and the low bits are equal.
- Counters increment with saturation: when a counter is at all-ones, an increment leaves it unchanged.
- `test_passed` = `done && fail_cnt==0 && pass_cnt!=0`. An empty test is not a pass.
- Reset: all of the following are 0 on the first rising edge with `rst_n` = 0, and the state is IDLE:
  - `evt_ready`, `fail_valid`, `fail_id`
  - `pass_cnt`, `fail_cnt`, `drop_cnt`
  - `busy`, `done`, `test_passed`

  Reset mid-test discards the FIFO contents and the counts.

## Timing
- All outputs are registered or decoded from registered state. No input→output combinational path exists except `fail_valid`/`fail_id`, which depend on state only, never on `fail_ready`.
- `start` in cycle N: `busy` = 1 and `evt_ready` = 1 in N+1.
- A failure accepted in cycle N appears on `fail_valid`/`fail_id` in N+1 if the FIFO was empty.
- Counters reflect an event accepted in cycle N from N+1.
- `finish` in N with the FIFO empty: DRAIN in N+1, DONE in N+2. DRAIN always lasts at least one cycle.
- Throughput: one event accepted and one record popped per cycle, sustained.

## Test plan
- Reset, then `start`, 5 passes, `finish`, no failures → `pass_cnt`=5, `fail_cnt`=0, `done`=1 two cycles after `finish`, `test_passed`=1.
- DEPTH=8, `fail_ready`=0, 10 failures with IDs 0x10..0x19 → `fail_cnt`=10, `drop_cnt`=2. Pops return 0x10..0x17 in order. `done` is asserted only after the 8th pop.
- FIFO full, failure and pop in the same cycle → push succeeds, `drop_cnt` unchanged, and the FIFO remains full.
- CNT_W=4, 20 passes → `pass_cnt` stays at 15. `start` in DONE → all counters read 0 on the next cycle.
- Pass event in the same cycle as `finish` → counted (`pass_cnt`=1). A subsequent `evt_valid` in DRAIN sees `evt_ready`=0 and is not counted.
- `rst_n` low for one cycle in RUN with 3 buffered failures → IDLE, `fail_valid`=0, all counters 0. `start` + `finish` in the same cycle then goes to RUN.
